// File: rtl/proc_run_sequencer_pkg.sv
// rtl/proc_run_sequencer_pkg.sv - shared types and constants for the processor run sequencer
// Purpose: state encoding, core geometry, branch-to-self decode shared by the sequencer files.
package proc_run_sequencer_pkg;

   localparam int ADDR_W           = 6;
   localparam int DATA_W           = 8;
   localparam int IMEM_DEPTH       = 1 << ADDR_W;
   localparam int BR_BIT           = 7;
   localparam int TGT_MSB          = 5;
   localparam int DRAIN_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARMED,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   // A branch whose target equals its own address never leaves: the core is halted.
   function automatic logic is_self_branch(input logic [DATA_W-1:0] instr,
                                           input logic [ADDR_W-1:0] pc);
      return instr[BR_BIT] && (instr[TGT_MSB:0] == pc);
   endfunction

endpackage

// File: rtl/proc_run_counter.sv
// rtl/proc_run_counter.sv - saturating cycle counter with clear, enable and terminal-count flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over enable)
//   i_en       : count enable
//   o_count    : current count, sticks at all-ones
//   o_tc       : high while o_count equals TERM
module proc_run_counter #(
   parameter int           W    = 16,
   parameter logic [W-1:0] TERM = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == TERM);

endmodule

// File: rtl/proc_run_sequencer.sv
// rtl/proc_run_sequencer.sv - run controller for the 3-stage 8-bit pipelined processor
// Ports:
//   clk, reset                       : clock, asynchronous active-low reset
//   start                            : level, begin a run of the loaded image
//   load_valid/data/last, load_ready : host byte stream into instruction memory
//   step_mode, step_req              : single-step control
//   halt_req                         : external abort
//   pc, instr_fetched                : core fetch observation for halt detect
//   imem_we/addr/wdata               : instruction memory write port
//   core_rst_n, core_en              : core reset and pipeline advance enable
//   busy, done, err                  : status (err sticky on timeout)
//   cycle_count, load_count          : enabled cycles of run, bytes of last load
module proc_run_sequencer
   import proc_run_sequencer_pkg::*;
#(
   parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int          CYC_W        = 16,
   parameter int unsigned MAX_CYCLES   = 16'hFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              step_mode,
   input  logic              step_req,
   input  logic              halt_req,
   input  logic [ADDR_W-1:0] pc,
   input  logic [DATA_W-1:0] instr_fetched,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_rst_n,
   output logic              core_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CYC_W-1:0]  cycle_count,
   output logic [ADDR_W:0]   load_count
);

   localparam int               DRN_W      = $clog2(DRAIN_CYCLES) + 1;
   localparam logic [CYC_W-1:0] TIMEOUT_TC = CYC_W'(MAX_CYCLES - 1);

   state_t              r_state;
   logic                r_we;
   logic [ADDR_W-1:0]   r_waddr;
   logic [DATA_W-1:0]   r_wdata;
   logic [ADDR_W:0]     r_load_count;
   logic                r_full;
   logic                r_err;
   logic [DRN_W-1:0]    r_drain;

   logic                w_ready_state;
   logic                w_accept;
   logic                w_first;
   logic                w_last_slot;
   logic                w_core_en;
   logic                w_halt;
   logic                w_timeout;
   logic                w_tc;
   logic                w_clr;

   assign w_ready_state = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);
   // After a full 64-byte image, hold off further beats until the host drops
   // load_valid so overflow bytes of the same stream are refused, not reloaded.
   assign load_ready    = reset && w_ready_state && !r_full;
   assign w_accept      = load_valid && load_ready;
   assign w_first       = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_last_slot   = (r_state == S_LOAD) &&
                          (r_load_count == (ADDR_W+1)'(IMEM_DEPTH - 1));

   assign w_core_en = (r_state == S_DRAIN) ||
                      ((r_state == S_RUN) && (!step_mode || step_req));
   assign w_halt    = w_core_en && is_self_branch(instr_fetched, pc);
   assign w_timeout = (r_state == S_RUN) && w_core_en && w_tc;
   assign w_clr     = (r_state == S_ARMED);

   proc_run_counter #(
      .W    (CYC_W),
      .TERM (TIMEOUT_TC)
   ) u_cycle_counter (
      .clk     (clk),
      .rst_n   (reset),
      .i_clr   (w_clr),
      .i_en    (w_core_en),
      .o_count (cycle_count),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_load_count <= '0;
         r_full       <= 1'b0;
         r_err        <= 1'b0;
         r_drain      <= '0;
      end else begin
         r_we <= w_accept;
         if (w_accept) begin
            r_wdata      <= load_data;
            r_waddr      <= w_first ? '0 : r_load_count[ADDR_W-1:0];
            r_load_count <= w_first ? (ADDR_W+1)'(1) : r_load_count + 1'b1;
         end

         if (w_accept && w_last_slot) begin
            r_full <= 1'b1;
         end else if (!load_valid) begin
            r_full <= 1'b0;
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_state <= load_last ? S_IDLE : S_LOAD;
               end else if (start) begin
                  r_state <= S_ARMED;
               end
            end
            S_LOAD: begin
               if (w_accept && (load_last || w_last_slot)) begin
                  r_state <= S_IDLE;
               end
            end
            S_ARMED: begin
               r_err   <= 1'b0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_timeout) begin
                  r_err <= 1'b1;
               end
               if (halt_req || w_halt || w_timeout) begin
                  r_drain <= '0;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_drain == DRN_W'(DRAIN_CYCLES - 1)) begin
                  r_state <= S_DONE;
               end else begin
                  r_drain <= r_drain + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_waddr;
   assign imem_wdata = r_wdata;
   assign core_en    = w_core_en;
   assign core_rst_n = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_DONE);
   assign busy       = (r_state == S_LOAD) || (r_state == S_ARMED) ||
                       (r_state == S_RUN)  || (r_state == S_DRAIN);
   assign done       = (r_state == S_DONE);
   assign err        = r_err;
   assign load_count = r_load_count;

endmodule

// File: tb/tb_proc_run_sequencer.sv
// tb/tb_proc_run_sequencer.sv - directed self-checking bench for proc_run_sequencer
module tb_proc_run_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, load_valid, load_last, step_mode, step_req, halt_req;
   logic [7:0]  load_data;
   logic        load_ready, imem_we, core_rst_n, core_en, busy, done, err;
   logic [5:0]  pc, imem_addr;
   logic [7:0]  instr_fetched, imem_wdata;
   logic [15:0] cycle_count;
   logic [6:0]  load_count;

   logic [7:0]  mem [0:63];
   logic [7:0]  img [0:15];
   logic [5:0]  wa_q [$];
   logic [7:0]  wd_q [$];
   int          en_cnt;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   proc_run_sequencer #(.MAX_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .step_mode(step_mode), .step_req(step_req),
      .halt_req(halt_req), .pc(pc), .instr_fetched(instr_fetched),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst_n(core_rst_n), .core_en(core_en), .busy(busy), .done(done),
      .err(err), .cycle_count(cycle_count), .load_count(load_count)
   );

   // Instruction memory and a PC that advances on every enabled cycle.
   assign instr_fetched = mem[pc];

   always @(posedge clk) begin
      if (!core_rst_n) pc <= 6'd0;
      else if (core_en) pc <= pc + 6'd1;
   end

   always @(negedge clk) begin
      if (imem_we) begin
         wa_q.push_back(imem_addr);
         wd_q.push_back(imem_wdata);
         mem[imem_addr] = imem_wdata;
      end
      if (core_en) en_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_img(input int n);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = img[i];
         load_last  = (i == n - 1);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      tick();
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if ({load_ready, imem_we, core_rst_n, core_en, busy, done, err} !== 7'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b required 0000000",
                  {load_ready, imem_we, core_rst_n, core_en, busy, done, err});
      end
      total++;
      if ({cycle_count, load_count} !== 23'd0) begin
         bad++;
         $display("FAIL reset_counts: cyc=%0d load=%0d required 0", cycle_count, load_count);
      end
      reset = 1'b1;
      tick();
      total++;
      if (load_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b required 1", load_ready);
      end
   endtask

   task automatic test_load4();
      wa_q.delete();
      wd_q.delete();
      img[0] = 8'h41; img[1] = 8'h0A; img[2] = 8'h13; img[3] = 8'h83;
      load_img(4);
      total++;
      if (wa_q.size() !== 4) begin
         bad++;
         $display("FAIL load4_writes: got %0d required 4", wa_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (wa_q[i] !== 6'(i) || wd_q[i] !== img[i]) begin
               bad++;
               $display("FAIL load4_beat%0d: addr=%0d data=%h required addr=%0d data=%h",
                        i, wa_q[i], wd_q[i], i, img[i]);
            end
         end
      end
      total++;
      if (load_count !== 7'd4 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL load4_end: load_count=%0d busy=%b done=%b required 4 0 0",
                  load_count, busy, done);
      end
   endtask

   task automatic test_overflow();
      logic ready_after_64 = 1'b1;
      wa_q.delete();
      wd_q.delete();
      for (int i = 0; i < 70; i++) begin
         load_valid = 1'b1;
         load_data  = 8'(i);
         load_last  = 1'b0;
         tick();
         if (i == 63) ready_after_64 = load_ready;
      end
      load_valid = 1'b0;
      tick();
      tick();
      total++;
      if (ready_after_64 !== 1'b0) begin
         bad++;
         $display("FAIL ovf_ready: got %b after 64th beat required 0", ready_after_64);
      end
      total++;
      if (wa_q.size() !== 64) begin
         bad++;
         $display("FAIL ovf_writes: got %0d required 64", wa_q.size());
      end else begin
         total++;
         if (wa_q[0] !== 6'd0 || wa_q[63] !== 6'd63 || wd_q[63] !== 8'd63) begin
            bad++;
            $display("FAIL ovf_addr: first=%0d last=%0d lastdata=%0d required 0 63 63",
                     wa_q[0], wa_q[63], wd_q[63]);
         end
      end
      total++;
      if (load_count !== 7'd64 || load_ready !== 1'b1) begin
         bad++;
         $display("FAIL ovf_end: load_count=%0d ready=%b required 64 1", load_count, load_ready);
      end
   endtask

   task automatic test_halt();
      load_img(4);
      en_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || core_rst_n !== 1'b0 || load_ready !== 1'b0) begin
         bad++;
         $display("FAIL halt_armed: busy=%b core_rst_n=%b ready=%b required 1 0 0",
                  busy, core_rst_n, load_ready);
      end
      wait_done(40);
      total++;
      if (cycle_count !== 16'd6 || en_cnt !== 6 || err !== 1'b0) begin
         bad++;
         $display("FAIL halt_count: cyc=%0d en=%0d err=%b required 6 6 0",
                  cycle_count, en_cnt, err);
      end
      total++;
      if (core_rst_n !== 1'b1 || core_en !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL halt_done: core_rst_n=%b core_en=%b busy=%b required 1 0 0",
                  core_rst_n, core_en, busy);
      end
   endtask

   task automatic test_step();
      en_cnt    = 0;
      step_mode = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         repeat (5) tick();
         total++;
         if (core_en !== 1'b0) begin
            bad++;
            $display("FAIL step_idle%0d: core_en=%b required 0", k, core_en);
         end
         step_req = 1'b1;
         #1;
         total++;
         if (core_en !== 1'b1) begin
            bad++;
            $display("FAIL step_pulse%0d: core_en=%b required 1", k, core_en);
         end
         tick();
         step_req = 1'b0;
      end
      repeat (3) tick();
      total++;
      if (en_cnt !== 3 || cycle_count !== 16'd3 || busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL step_count: en=%0d cyc=%0d busy=%b done=%b required 3 3 1 0",
                  en_cnt, cycle_count, busy, done);
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      wait_done(10);
      total++;
      if (cycle_count !== 16'd5 || err !== 1'b0) begin
         bad++;
         $display("FAIL step_abort: cyc=%0d err=%b required 5 0", cycle_count, err);
      end
      step_mode = 1'b0;
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 16; i++) img[i] = 8'h01;
      load_img(16);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(40);
      total++;
      if (err !== 1'b1 || cycle_count !== 16'd12) begin
         bad++;
         $display("FAIL timeout: err=%b cyc=%0d required 1 12", err, cycle_count);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      total++;
      if (err !== 1'b0 || cycle_count !== 16'd0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rerun_clear: err=%b cyc=%0d busy=%b required 0 0 1",
                  err, cycle_count, busy);
      end
   endtask

   task automatic test_mid_reset();
      total++;
      if (core_en !== 1'b1 || core_rst_n !== 1'b1) begin
         bad++;
         $display("FAIL midrst_run: core_en=%b core_rst_n=%b required 1 1", core_en, core_rst_n);
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (core_rst_n !== 1'b0 || core_en !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL midrst_drop: core_rst_n=%b core_en=%b busy=%b required 0 0 0",
                  core_rst_n, core_en, busy);
      end
      #3;
      reset = 1'b1;
      tick();
      total++;
      if (load_ready !== 1'b1 || cycle_count !== 16'd0 || load_count !== 7'd0 || err !== 1'b0) begin
         bad++;
         $display("FAIL midrst_release: ready=%b cyc=%0d load=%0d err=%b required 1 0 0 0",
                  load_ready, cycle_count, load_count, err);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      reset      = 1'b0;
      start      = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      step_mode  = 1'b0;
      step_req   = 1'b0;
      halt_req   = 1'b0;
      en_cnt     = 0;
      test_reset();
      test_load4();
      test_overflow();
      test_halt();
      test_step();
      test_timeout();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
